// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: arbitrates NUM_MASTERS AXI read masters onto one downstream port,
// one transaction outstanding at a time, round-robin or fixed priority.
module axi_read_arbiter #(
   parameter int NUM_MASTERS = 2,
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int ARLEN_WIDTH = 8,
   parameter int FIXED_PRIO  = 0,
   localparam int GW = $clog2(NUM_MASTERS)
) (
   input  logic                                    clk,
   input  logic                                    rst_n,
   input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0]  m_araddr,
   input  logic [NUM_MASTERS-1:0][ARLEN_WIDTH-1:0] m_arlen,
   input  logic [NUM_MASTERS-1:0][2:0]             m_arsize,
   input  logic [NUM_MASTERS-1:0][1:0]             m_arburst,
   input  logic [NUM_MASTERS-1:0]                  m_arvalid,
   output logic [NUM_MASTERS-1:0]                  m_arready,
   output logic [DATA_WIDTH-1:0]                   m_rdata,
   output logic [1:0]                              m_rresp,
   output logic                                    m_rlast,
   output logic [NUM_MASTERS-1:0]                  m_rvalid,
   input  logic [NUM_MASTERS-1:0]                  m_rready,
   output logic [ADDR_WIDTH-1:0]                   s_araddr,
   output logic [ARLEN_WIDTH-1:0]                  s_arlen,
   output logic [2:0]                              s_arsize,
   output logic [1:0]                              s_arburst,
   output logic                                    s_arvalid,
   input  logic                                    s_arready,
   input  logic [DATA_WIDTH-1:0]                   s_rdata,
   input  logic [1:0]                              s_rresp,
   input  logic                                    s_rlast,
   input  logic                                    s_rvalid,
   output logic                                    s_rready,
   output logic [GW-1:0]                           grant_id,
   output logic                                    busy,
   output logic                                    len_err
);
   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
   localparam logic [NUM_MASTERS-1:0] one_hot0 = 1;
   localparam logic [ARLEN_WIDTH:0]   cnt_one  = 1;
   state_t               state, state_nxt;
   logic [GW-1:0]        last_grant, winner;
   logic [ARLEN_WIDTH:0] cnt;
   logic                 found, r_hs;
   int                   start, idx;
   assign s_arvalid = state == ADDR;
   assign busy      = state != IDLE;
   assign s_rready  = state == DATA && m_rready[grant_id];
   assign r_hs      = s_rready && s_rvalid;
   assign m_arready = s_arvalid && s_arready ? one_hot0 << grant_id : '0;
   assign m_rvalid  = state == DATA && s_rvalid ? one_hot0 << grant_id : '0;
   assign m_rdata   = s_rdata;
   assign m_rresp   = s_rresp;
   assign m_rlast   = s_rlast;
   always_comb begin
      state_nxt = state;
      start = (FIXED_PRIO != 0 || int'(last_grant) == NUM_MASTERS - 1) ? 0 : int'(last_grant) + 1;
      winner = '0;
      found = 1'b0;
      idx = 0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         idx = start + i >= NUM_MASTERS ? start + i - NUM_MASTERS : start + i;
         if (!found && m_arvalid[idx]) begin
            winner = GW'(idx);
            found = 1'b1;
         end
      end
      case (state)
         IDLE:    state_nxt = found ? ADDR : IDLE;
         ADDR:    state_nxt = s_arready ? DATA : ADDR;
         DATA:    state_nxt = r_hs && s_rlast ? IDLE : DATA;
         default: state_nxt = IDLE;
      endcase
   end
   // AR fields are captured at arbitration so they stay stable however long the slave stalls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_grant <= GW'(NUM_MASTERS - 1);
         grant_id   <= '0;
         cnt        <= '0;
         len_err    <= 1'b0;
         s_araddr   <= '0;
         s_arlen    <= '0;
         s_arsize   <= '0;
         s_arburst  <= '0;
      end else begin
         state   <= state_nxt;
         len_err <= 1'b0;
         if (state == IDLE && found) begin
            grant_id  <= winner;
            s_araddr  <= m_araddr[winner];
            s_arlen   <= m_arlen[winner];
            s_arsize  <= m_arsize[winner];
            s_arburst <= m_arburst[winner];
         end
         if (s_arvalid && s_arready) cnt <= {1'b0, s_arlen};
         if (r_hs) begin
            cnt     <= cnt == '0 ? cnt : cnt - cnt_one;
            len_err <= s_rlast != (cnt == '0);
            if (s_rlast) last_grant <= grant_id;
         end
      end
   end
endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb_axi_read_arbiter: directed scoreboard bench; a round-robin and a fixed-priority
// instance share all inputs and run in lockstep against one behavioural slave.
module tb_axi_read_arbiter;
   localparam int NM = 4;
   typedef struct {int g; int len;} ar_t;
   typedef struct {int g; logic [31:0] d; logic [1:0] resp; logic last;} r_t;
   logic clk = 1'b0, rst_n = 1'b0;
   logic [NM-1:0][31:0] m_araddr;
   logic [NM-1:0][7:0]  m_arlen;
   logic [NM-1:0][2:0]  m_arsize;
   logic [NM-1:0][1:0]  m_arburst;
   logic [NM-1:0]       m_arvalid, m_rready, req, keep, served, pend_m;
   logic [NM-1:0]       m_arready, m_rvalid, f_m_arready, f_m_rvalid;
   logic [31:0]         m_rdata, f_m_rdata, s_araddr, f_s_araddr, s_rdata, sl_addr;
   logic [1:0]          m_rresp, f_m_rresp, s_arburst, f_s_arburst, s_rresp, grant_id, f_grant_id;
   logic [7:0]          s_arlen, f_s_arlen;
   logic [2:0]          s_arsize, f_s_arsize;
   logic m_rlast, f_m_rlast, s_arvalid, f_s_arvalid, s_rready, f_s_rready, busy, f_busy, len_err, f_len_err;
   logic s_arready, s_rlast, s_rvalid;
   ar_t  exp_ar[$];
   r_t   exp_r[$];
   int   exp_fp[$];
   int   exp_lerr = 0, checks = 0, errors = 0;
   int   ar_delay = 0, early = 999, ar_cnt = 0, sl_len = 0, sl_beat = 0;
   bit   in_data = 0, pend_ar = 0, pend_r = 0, pend_last = 0;

   assign m_arvalid = req & ~served;
   always #5 clk = ~clk;

   axi_read_arbiter #(.NUM_MASTERS(NM), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ARLEN_WIDTH(8), .FIXED_PRIO(0)) u_rr (
      .clk(clk), .rst_n(rst_n), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
      .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready), .m_rdata(m_rdata),
      .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
      .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
      .s_arvalid(s_arvalid), .s_arready(s_arready), .s_rdata(s_rdata), .s_rresp(s_rresp),
      .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready), .grant_id(grant_id),
      .busy(busy), .len_err(len_err));

   axi_read_arbiter #(.NUM_MASTERS(NM), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ARLEN_WIDTH(8), .FIXED_PRIO(1)) u_fp (
      .clk(clk), .rst_n(rst_n), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
      .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(f_m_arready), .m_rdata(f_m_rdata),
      .m_rresp(f_m_rresp), .m_rlast(f_m_rlast), .m_rvalid(f_m_rvalid), .m_rready(m_rready),
      .s_araddr(f_s_araddr), .s_arlen(f_s_arlen), .s_arsize(f_s_arsize), .s_arburst(f_s_arburst),
      .s_arvalid(f_s_arvalid), .s_arready(s_arready), .s_rdata(s_rdata), .s_rresp(s_rresp),
      .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(f_s_rready), .grant_id(f_grant_id),
      .busy(f_busy), .len_err(f_len_err));

   function automatic logic [31:0] addr_of(input int g);
      return 32'h100 + 32'(g) * 32'h1000;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_txn(input int g, input int len, input int e);
      int fin;
      r_t r;
      fin = e < len ? e : len;
      exp_ar.push_back('{g: g, len: len});
      for (int b = 0; b <= fin; b++) begin
         r.g = g;
         r.d = addr_of(g) + 32'(b);
         r.resp = 2'(b);
         r.last = b == fin;
         exp_r.push_back(r);
      end
      if (e < len) exp_lerr++;
   endtask

   task automatic reset_dut();
      @(negedge clk);
      #3 req = '0;
      rst_n = 1'b0;
      #1 chk("rst_rr", {s_arvalid, s_rready, m_arready, m_rvalid, busy, len_err, grant_id}, 0);
      chk("rst_fp", {f_s_arvalid, f_s_rready, f_m_arready, f_m_rvalid, f_busy, f_len_err, f_grant_id}, 0);
      @(negedge clk);
      #3 rst_n = 1'b1;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (n < budget && !(exp_ar.size() == 0 && exp_r.size() == 0 && exp_fp.size() == 0 && !busy && !f_busy)) begin
         @(negedge clk);
         #3 n++;
      end
      chk("idle_timeout", n >= budget, 0);
      chk("len_err_missing", exp_lerr, 0);
      req = '0;
   endtask

   task automatic wait_ar_empty(input int budget);
      int n = 0;
      while (n < budget && !(exp_ar.size() == 0 && exp_fp.size() == 0)) begin
         @(negedge clk);
         #3 n++;
      end
      chk("ar_timeout", n >= budget, 0);
   endtask

   // slave and master-side bookkeeping: acts on the handshakes seen before the last rising edge
   initial begin
      s_arready = 0; s_rvalid = 0; s_rlast = 0; s_rdata = '0; s_rresp = '0; served = '0;
      sl_addr = '0; pend_m = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            in_data = 0; pend_ar = 0; pend_r = 0; ar_cnt = 0; served = '0;
            s_arready = 0; s_rvalid = 0; s_rlast = 0;
         end else begin
            if (pend_ar) begin
               in_data = 1; sl_beat = 0; ar_cnt = 0;
               served = served | (pend_m & ~keep);
            end
            served = served & req;
            if (pend_r) begin
               if (pend_last) in_data = 0;
               else sl_beat++;
            end
            s_arready = !in_data && s_arvalid && ar_cnt >= ar_delay;
            if (s_arvalid && !in_data) ar_cnt++;
            s_rvalid = in_data;
            s_rdata = sl_addr + 32'(sl_beat);
            s_rresp = 2'(sl_beat);
            s_rlast = in_data && (sl_beat == sl_len || sl_beat == early);
            #1 pend_ar = s_arvalid && s_arready;
            pend_m = m_arready & m_arvalid;
            if (pend_ar) begin
               sl_len = int'(s_arlen);
               sl_addr = s_araddr;
            end
            pend_r = s_rvalid && s_rready;
            pend_last = s_rlast;
         end
      end
   end

   initial begin
      ar_t e;
      r_t r;
      int g;
      forever begin
         @(negedge clk);
         #2;
         if (s_arvalid && s_arready) begin
            if (exp_ar.size() == 0) chk("ar_unexpected", grant_id, 4'hf);
            else begin
               e = exp_ar.pop_front();
               chk("ar_grant", grant_id, e.g);
               chk("ar_addr", s_araddr, addr_of(e.g));
               chk("ar_len", s_arlen, e.len);
               chk("ar_size_burst", {s_arsize, s_arburst}, {3'(e.g), 2'(e.g)});
               chk("ar_ready", m_arready, 4'b1 << e.g);
            end
         end
         if (f_s_arvalid && s_arready) begin
            if (exp_fp.size() == 0) chk("fp_unexpected", f_grant_id, 4'hf);
            else begin
               g = exp_fp.pop_front();
               chk("fp_grant", f_grant_id, g);
               chk("fp_addr", f_s_araddr, addr_of(g));
            end
         end
         if ((m_rvalid & m_rready) != '0) begin
            if (exp_r.size() == 0) chk("r_unexpected", m_rvalid, 0);
            else begin
               r = exp_r.pop_front();
               chk("r_valid", m_rvalid, 4'b1 << r.g);
               chk("r_data", m_rdata, r.d);
               chk("r_resp_last", {m_rresp, m_rlast}, {r.resp, r.last});
            end
         end
         if (len_err) begin
            chk("len_err_unexpected", exp_lerr == 0, 0);
            if (exp_lerr > 0) exp_lerr--;
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
      $fatal(1);
   end

   initial begin
      int n;
      req = '0; keep = '0; m_rready = '1;
      for (int i = 0; i < NM; i++) begin
         m_araddr[i] = addr_of(i);
         m_arlen[i] = 8'd1;
         m_arsize[i] = 3'(i);
         m_arburst[i] = 2'(i);
      end
      reset_dut();
      // single master, 4-beat burst, one-cycle AR latency
      m_arlen[0] = 8'd3;
      @(negedge clk);
      #3 push_txn(0, 3, 999);
      exp_fp.push_back(0);
      req = 4'b0001;
      #1 chk("lat_idle", s_arvalid, 0);
      @(negedge clk);
      #3 chk("lat_addr", {s_arvalid, busy, s_araddr}, {1'b1, 1'b1, 32'h100});
      wait_idle(100);
      chk("grant_hold0", {grant_id, busy}, {2'd0, 1'b0});
      // round-robin fairness with every master requesting; reset restarts the search at 0
      reset_dut();
      m_arlen[0] = 8'd1;
      @(negedge clk);
      #3 foreach (exp_fp[i]) exp_fp.delete();
      push_txn(0, 1, 999); push_txn(1, 1, 999); push_txn(2, 1, 999); push_txn(3, 1, 999); push_txn(0, 1, 999);
      for (int k = 0; k < 5; k++) exp_fp.push_back(0);
      keep = '1; req = '1;
      wait_ar_empty(200);
      req = '0; keep = '0;
      wait_idle(100);
      // masters 1 and 3 contend: rr alternates, fixed priority always picks 1
      reset_dut();
      @(negedge clk);
      #3 push_txn(1, 1, 999); push_txn(3, 1, 999); push_txn(1, 1, 999);
      exp_fp.push_back(1); exp_fp.push_back(1); exp_fp.push_back(1);
      keep = 4'b1010; req = 4'b1010;
      wait_ar_empty(200);
      req = '0; keep = '0;
      wait_idle(100);
      // slave stalls AR for 5 cycles
      @(negedge clk);
      #3 m_arlen[2] = 8'd0;
      ar_delay = 5;
      push_txn(2, 0, 999);
      exp_fp.push_back(2);
      req = 4'b0100;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         #3 chk("ar_stall", {s_arvalid, m_arready, s_araddr, s_arlen}, {1'b1, 4'b0, addr_of(2), 8'd0});
      end
      wait_idle(100);
      ar_delay = 0;
      @(negedge clk);
      #3 chk("grant_hold2", {grant_id, busy}, {2'd2, 1'b0});
      // early rlast on beat 2 of a 4-beat burst
      m_arlen[0] = 8'd3;
      early = 1;
      push_txn(0, 3, 1);
      exp_fp.push_back(0);
      req = 4'b0001;
      wait_idle(100);
      early = 999;
      // reset while beat 2 is on the bus, then arbitration restarts at master 0
      @(negedge clk);
      #3 m_arlen[1] = 8'd3;
      push_txn(1, 3, 999);
      exp_fp.push_back(1);
      req = 4'b0010;
      n = 0;
      while (exp_r.size() > 2 && n < 100) begin
         @(negedge clk);
         #3 n++;
      end
      chk("mid_wait_timeout", n >= 100, 0);
      rst_n = 1'b0;
      #1 chk("mid_rst_rr", {s_arvalid, s_rready, m_arready, m_rvalid, busy, len_err, grant_id}, 0);
      chk("mid_rst_fp", {f_s_arvalid, f_s_rready, f_m_arready, f_m_rvalid, f_busy, f_len_err, f_grant_id}, 0);
      exp_r.delete();
      req = '0;
      @(negedge clk);
      #3 rst_n = 1'b1;
      m_arlen[3] = 8'd3;
      push_txn(0, 3, 999); push_txn(3, 3, 999);
      exp_fp.push_back(0); exp_fp.push_back(3);
      req = 4'b1001;
      wait_idle(200);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
